// File: rtl/ddr4_rdata_capture_pkg.sv
// Shared constants for the DDR4 read-data capture slice.
package ddr4_rdata_capture_pkg;

   localparam int unsigned DQ_WIDTH_DEF = 64;
   localparam int unsigned DQ_BURST_DEF = 8;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;

endpackage

// File: rtl/ddr4_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; head is presented combinationally from storage.
module ddr4_rd_fifo #(
   parameter int unsigned WIDTH = 512,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_FULL);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);

   always_comb begin
      level_d = level_q;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

   // Storage is not reset, so mask the head while empty.
   assign dout  = empty ? '0 : mem[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/ddr4_rdata_capture.sv
// Read-data capture: registers PHY read bursts, drops dummy reads and buffers real
// bursts in a FWFT FIFO for the host readback path.
module ddr4_rdata_capture
   import ddr4_rdata_capture_pkg::*;
#(
   parameter int unsigned DQ_WIDTH   = DQ_WIDTH_DEF,
   parameter int unsigned DQ_BURST   = DQ_BURST_DEF,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              init_calib_complete,
   input  logic [DQ_WIDTH*DQ_BURST-1:0]      rdData,
   input  logic                              rdDataEn,
   input  logic                              iss_dummy_read,
   output logic                              rd_valid,
   output logic [DQ_WIDTH*DQ_BURST-1:0]      rd_data,
   input  logic                              rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
   output logic                              overflow,
   input  logic                              clr_overflow,
   output logic [CNT_WIDTH-1:0]              dummy_cnt
);

   localparam int unsigned DW = DQ_WIDTH * DQ_BURST;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                 calib_q;
   logic                 in_valid_q, in_dummy_q;
   logic [DW-1:0]        in_data_q;
   logic [CNT_WIDTH-1:0] dummy_cnt_q, dummy_cnt_d;
   logic                 overflow_q, overflow_d;

   logic push_req, dummy_hit, fifo_pop, fifo_empty, fifo_full, overflow_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         calib_q    <= LOW;
         in_valid_q <= LOW;
         in_dummy_q <= LOW;
         in_data_q  <= '0;
      end else begin
         calib_q    <= calib_q | init_calib_complete;
         in_valid_q <= rdDataEn & calib_q;
         in_dummy_q <= iss_dummy_read;
         in_data_q  <= rdData;
      end
   end

   assign push_req  = in_valid_q & ~in_dummy_q;
   assign dummy_hit = in_valid_q & in_dummy_q;
   assign fifo_pop  = rd_valid & rd_ready;
   // Only a push that cannot ride along with a pop is lost.
   assign overflow_set = push_req & fifo_full & ~fifo_pop;

   always_comb begin
      dummy_cnt_d = dummy_cnt_q;
      if (dummy_hit && (dummy_cnt_q != '1)) dummy_cnt_d = dummy_cnt_q + CNT_ONE;
   end

   always_comb begin
      overflow_d = overflow_q;
      if (overflow_set)      overflow_d = HIGH;
      else if (clr_overflow) overflow_d = LOW;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dummy_cnt_q <= '0;
         overflow_q  <= LOW;
      end else begin
         dummy_cnt_q <= dummy_cnt_d;
         overflow_q  <= overflow_d;
      end
   end

   ddr4_rd_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .din   (in_data_q),
      .pop   (fifo_pop),
      .dout  (rd_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (fifo_level)
   );

   assign rd_valid  = ~fifo_empty;
   assign overflow  = overflow_q;
   assign dummy_cnt = dummy_cnt_q;

endmodule

// File: tb/tb_ddr4_rdata_capture.sv
// Directed self-checking bench for ddr4_rdata_capture.
module tb_ddr4_rdata_capture;

   localparam int unsigned DW = 512;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           init_calib_complete;
   logic [DW-1:0]  rdData;
   logic           rdDataEn;
   logic           iss_dummy_read;
   logic           rd_valid;
   logic [DW-1:0]  rd_data;
   logic           rd_ready;
   logic [4:0]     fifo_level;
   logic           overflow;
   logic           clr_overflow;
   logic [15:0]    dummy_cnt;

   int n_cmp = 0;
   int n_err = 0;

   ddr4_rdata_capture #(
      .DQ_WIDTH   (64),
      .DQ_BURST   (8),
      .FIFO_DEPTH (16),
      .CNT_WIDTH  (16)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .init_calib_complete (init_calib_complete),
      .rdData              (rdData),
      .rdDataEn            (rdDataEn),
      .iss_dummy_read      (iss_dummy_read),
      .rd_valid            (rd_valid),
      .rd_data             (rd_data),
      .rd_ready            (rd_ready),
      .fifo_level          (fifo_level),
      .overflow            (overflow),
      .clr_overflow        (clr_overflow),
      .dummy_cnt           (dummy_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] held, d;
   logic          stall;
   int            p, sent, recv;

   initial begin
      rst_n = 1'b0; init_calib_complete = 1'b0; rdData = '0; rdDataEn = 1'b0;
      iss_dummy_read = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
      #12;
      check("rst_valid", DW'(rd_valid), '0);
      check("rst_data", rd_data, '0);
      check("rst_level", DW'(fifo_level), '0);
      check("rst_ovf", DW'(overflow), '0);
      check("rst_dcnt", DW'(dummy_cnt), '0);
      step();
      rst_n = 1'b1;
      step();

      // Calibration gate
      rdDataEn = 1'b1; rdData = DW'(32'hAA);
      step(); step();
      rdDataEn = 1'b0;
      step(); step();
      check("precal_level", DW'(fifo_level), '0);
      check("precal_valid", DW'(rd_valid), '0);
      init_calib_complete = 1'b1;
      step();
      for (int i = 1; i <= 3; i++) begin
         rdDataEn = 1'b1; rdData = DW'(i);
         step();
         if (i == 1) check("cal_n1_valid", DW'(rd_valid), '0);
      end
      rdDataEn = 1'b0;
      check("cal_n2_valid", DW'(rd_valid), DW'(1));
      check("cal_n2_data", rd_data, DW'(1));
      step(); step();
      check("cal_level", DW'(fifo_level), DW'(3));
      for (int i = 1; i <= 3; i++) begin
         check("cal_order", rd_data, DW'(i));
         rd_ready = 1'b1;
         step();
      end
      rd_ready = 1'b0;
      check("cal_drained", DW'(rd_valid), '0);

      // Dummy filtering: pattern 1,0,1,0
      for (int i = 0; i < 4; i++) begin
         rdDataEn = 1'b1; iss_dummy_read = (i % 2 == 0); rdData = DW'(16'h10 + i);
         step();
      end
      rdDataEn = 1'b0; iss_dummy_read = 1'b0;
      step(); step();
      check("dum_cnt", DW'(dummy_cnt), DW'(2));
      check("dum_level", DW'(fifo_level), DW'(2));
      check("dum_head1", rd_data, DW'(16'h11));
      rd_ready = 1'b1; step();
      check("dum_head2", rd_data, DW'(16'h13));
      step();
      rd_ready = 1'b0;
      check("dum_empty", DW'(rd_valid), '0);

      // Full and overflow: 17 bursts into a 16-deep FIFO
      for (int i = 0; i < 17; i++) begin
         rdDataEn = 1'b1; rdData = DW'(16'h100 + i);
         step();
      end
      rdDataEn = 1'b0;
      step(); step();
      check("ovf_level", DW'(fifo_level), DW'(16));
      check("ovf_flag", DW'(overflow), DW'(1));
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_drain", rd_data, DW'(16'h100 + i));
         step();
      end
      rd_ready = 1'b0;
      check("ovf_b17_dropped", DW'(rd_valid), '0);
      check("ovf_sticky", DW'(overflow), DW'(1));
      clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
      check("ovf_clr", DW'(overflow), '0);

      // Full with simultaneous pop across pointer wrap
      for (int i = 0; i < 16; i++) begin
         rdDataEn = 1'b1; rdData = DW'(16'h200 + i);
         step();
      end
      rdDataEn = 1'b0;
      step(); step();
      p = 0;
      for (int c = 0; c < 22; c++) begin
         check("fp_level", DW'(fifo_level), DW'(16));
         d = (p < 16) ? DW'(16'h200 + p) : DW'(16'h300 + p - 16);
         check("fp_head", rd_data, d);
         rdDataEn = (c < 20); rdData = DW'(16'h300 + c);
         rd_ready = (c >= 1);
         if (c >= 1) p++;
         step();
      end
      rdDataEn = 1'b0;
      for (int k = 0; k < 15; k++) begin
         check("fp_tail", rd_data, DW'(16'h300 + p - 16));
         p++;
         step();
      end
      rd_ready = 1'b0;
      check("fp_empty", DW'(rd_valid), '0);
      check("fp_no_ovf", DW'(overflow), '0);

      // Backpressure with scoreboard
      sent = 0; recv = 0; stall = 1'b0; held = '0;
      for (int cyc = 0; cyc < 2000 && recv < 100; cyc++) begin
         if (stall) check("bp_stable", rd_data, held);
         rd_ready = $urandom_range(0, 1) == 1;
         if (rd_valid && rd_ready) begin
            check("bp_data", rd_data, exp_q.pop_front());
            recv++;
         end
         stall = rd_valid & ~rd_ready;
         held  = rd_data;
         rdDataEn = 1'b0;
         if (sent < 100 && exp_q.size() < 14 && $urandom_range(0, 3) != 0) begin
            d = {16{$urandom}};
            rdDataEn = 1'b1; rdData = d;
            exp_q.push_back(d);
            sent++;
         end
         step();
      end
      rd_ready = 1'b0; rdDataEn = 1'b0;
      check("bp_recv", DW'(recv), DW'(100));
      check("bp_empty", DW'(rd_valid), '0);
      check("bp_no_ovf", DW'(overflow), '0);

      // Reset mid-operation
      for (int i = 0; i < 5; i++) begin
         rdDataEn = 1'b1; rdData = DW'(16'h400 + i);
         step();
      end
      step();
      check("mr_level5", DW'(fifo_level), DW'(5));
      rdDataEn = 1'b1; rdData = DW'(16'h4FF);
      #3;
      rst_n = 1'b0; init_calib_complete = 1'b0;
      #1;
      check("mr_valid", DW'(rd_valid), '0);
      check("mr_data", rd_data, '0);
      check("mr_level", DW'(fifo_level), '0);
      check("mr_ovf", DW'(overflow), '0);
      check("mr_dcnt", DW'(dummy_cnt), '0);
      step();
      rst_n = 1'b1;
      step(); step(); step();
      rdDataEn = 1'b0;
      check("mr_post_valid", DW'(rd_valid), '0);
      init_calib_complete = 1'b1;
      step();
      rdDataEn = 1'b1; rdData = DW'(16'h55);
      step();
      rdDataEn = 1'b0;
      step();
      check("mr_new_valid", DW'(rd_valid), DW'(1));
      check("mr_new_data", rd_data, DW'(16'h55));
      check("mr_new_level", DW'(fifo_level), DW'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
